// File: rtl/pipe_skid_stage.sv
`default_nettype none
// ============================================================================
// Module   : pipe_skid_stage
// Purpose  : Parametrised valid/ready pipeline-stage register. A two-entry
//            skid buffer (main + skid) gives one payload per cycle with a
//            registered in_ready. A synchronous flush turns the stage into a
//            bubble.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   DATA_W    : payload width in bits (>= 1)
//   RESET_VAL : value loaded into main/skid on reset and on flush
//   CNT_W     : stall counter width (used only with PIPE_STALL_CNT_EN)
// Ports
//   CLK       : clock, rising edge
//   nRST      : asynchronous active-low reset
//   flush     : synchronous squash of all held entries
//   in_valid  : upstream has a payload
//   in_ready  : stage can accept (decoded from the state register only)
//   in_data   : upstream payload
//   out_valid : out_data holds a live payload
//   out_ready : downstream accepts out_data this cycle
//   out_data  : head payload, always the main register
//   level     : entries held (0, 1 or 2)
//   stall_cnt : saturating count of cycles with in_valid=1 and in_ready=0
// Build option
//   PIPE_STALL_CNT_EN : when defined, stall_cnt is implemented; otherwise it
//                       is tied to zero.
// ============================================================================
module pipe_skid_stage #(
    parameter int                 DATA_W    = 64,
    parameter logic [DATA_W-1:0]  RESET_VAL = '0,
    parameter int                 CNT_W     = 16
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        level,
    output logic [CNT_W-1:0]  stall_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKID  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] main_q,  main_d;
    logic [DATA_W-1:0] skid_q,  skid_d;
    logic              accept;
    logic              emit;

    // Handshake outputs decode straight from the state register, so in_ready
    // has no combinational path from any input.
    assign in_ready  = (state_q != SKID);
    assign out_valid = (state_q != EMPTY);
    assign out_data  = main_q;
    assign accept    = in_valid & in_ready;
    assign emit      = out_valid & out_ready;

    always_comb begin
        level = 2'd0;
        case (state_q)
            FULL:    level = 2'd1;
            SKID:    level = 2'd2;
            default: level = 2'd0;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= EMPTY;
            main_q  <= RESET_VAL;
            skid_q  <= RESET_VAL;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            // Flush wins over everything; an accept this cycle is dropped.
            state_d = EMPTY;
            main_d  = RESET_VAL;
            skid_d  = RESET_VAL;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        main_d  = in_data;
                        state_d = FULL;
                    end
                end
                FULL: begin
                    if (accept && emit) begin
                        main_d  = in_data;
                    end else if (accept) begin
                        // Head is stalled: park the newcomer behind it.
                        skid_d  = in_data;
                        state_d = SKID;
                    end else if (emit) begin
                        state_d = EMPTY;
                    end
                end
                SKID: begin
                    if (emit) begin
                        main_d  = skid_q;
                        state_d = FULL;
                    end
                end
                default: begin
                    state_d = EMPTY;
                end
            endcase
        end
    end

`ifdef PIPE_STALL_CNT_EN
    logic [CNT_W-1:0] cnt_q;

    // Cleared by reset only; flush intentionally leaves the count alone.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            cnt_q <= '0;
        end else if (in_valid && !in_ready && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign stall_cnt = cnt_q;
`else
    assign stall_cnt = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_skid_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_skid_stage
// Purpose  : Self-checking bench for pipe_skid_stage. Directed vector table,
//            hand-written reset/flush/counter sequences and a randomized run
//            checked against a queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_skid_stage;

    localparam int          DW   = 8;
    localparam logic [7:0]  RV   = 8'h5A;
    localparam int          CW   = 2;
    localparam int          CMAX = (1 << CW) - 1;

    logic          CLK;
    logic          nRST;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [1:0]    level;
    logic [CW-1:0] stall_cnt;

    int checks = 0;
    int errors = 0;

    pipe_skid_stage #(
        .DATA_W    (DW),
        .RESET_VAL (RV),
        .CNT_W     (CW)
    ) dut (
        .CLK       (CLK),
        .nRST      (nRST),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .level     (level),
        .stall_cnt (stall_cnt)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // ---------------- reference model: FIFO of at most two payloads --------
    logic [DW-1:0] mq[$];
    logic [DW-1:0] stale;     // value left visible on out_data when empty
    int            mcnt;

    task automatic model_reset();
        mq.delete();
        stale = RV;
        mcnt  = 0;
    endtask

    task automatic model_update(input logic fl, input logic iv,
                                input logic [DW-1:0] d, input logic ordy);
        bit            rdy;
        bit            acc;
        bit            em;
        logic [DW-1:0] popped;
        rdy = (mq.size() != 2);
        acc = iv && rdy;
        em  = (mq.size() > 0) && ordy;
`ifdef PIPE_STALL_CNT_EN
        if (iv && !rdy && mcnt < CMAX) mcnt++;
`endif
        if (fl) begin
            mq.delete();
            stale = RV;
        end else begin
            if (em) begin
                popped = mq.pop_front();
                if (mq.size() == 0) stale = popped;
            end
            if (acc) mq.push_back(d);
        end
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, ".out_valid"}, int'(out_valid), int'(mq.size() > 0));
        check({tag, ".in_ready"},  int'(in_ready),  int'(mq.size() != 2));
        check({tag, ".level"},     int'(level),     mq.size());
        check({tag, ".out_data"},  int'(out_data),  int'((mq.size() > 0) ? mq[0] : stale));
        check({tag, ".stall_cnt"}, int'(stall_cnt), mcnt);
    endtask

    // Drive one cycle of inputs, advance the model at the edge, then compare.
    task automatic step(input string tag, input logic fl, input logic iv,
                        input logic [DW-1:0] d, input logic ordy);
        flush     = fl;
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        @(posedge CLK);
        model_update(fl, iv, d, ordy);
        #1;
        check_model(tag);
    endtask

    // ---------------- directed vector table --------------------------------
    typedef struct {
        logic          fl;
        logic          iv;
        logic [DW-1:0] d;
        logic          ordy;
        logic          e_ov;
        logic [DW-1:0] e_od;
        logic [1:0]    e_lvl;
        logic          e_rdy;
    } vec_t;

    vec_t vt[18];

    initial begin
        // Streaming at full rate
        vt[0]  = '{0, 1, 8'h11, 1, 1, 8'h11, 2'd1, 1};
        vt[1]  = '{0, 1, 8'h22, 1, 1, 8'h22, 2'd1, 1};
        vt[2]  = '{0, 1, 8'h33, 1, 1, 8'h33, 2'd1, 1};
        vt[3]  = '{0, 0, 8'h00, 1, 0, 8'h33, 2'd0, 1};
        // Backpressure, held 0xC while full, then drain in order
        vt[4]  = '{0, 1, 8'h0A, 0, 1, 8'h0A, 2'd1, 1};
        vt[5]  = '{0, 1, 8'h0B, 0, 1, 8'h0A, 2'd2, 0};
        vt[6]  = '{0, 1, 8'h0C, 0, 1, 8'h0A, 2'd2, 0};
        vt[7]  = '{0, 1, 8'h0C, 0, 1, 8'h0A, 2'd2, 0};
        vt[8]  = '{0, 1, 8'h0C, 0, 1, 8'h0A, 2'd2, 0};
        vt[9]  = '{0, 1, 8'h0C, 1, 1, 8'h0B, 2'd1, 1};
        vt[10] = '{0, 1, 8'h0C, 1, 1, 8'h0C, 2'd1, 1};
        vt[11] = '{0, 0, 8'h00, 1, 0, 8'h0C, 2'd0, 1};
        // Flush in SKID together with an offered 0xD
        vt[12] = '{0, 1, 8'h0A, 0, 1, 8'h0A, 2'd1, 1};
        vt[13] = '{0, 1, 8'h0B, 0, 1, 8'h0A, 2'd2, 0};
        vt[14] = '{1, 1, 8'h0D, 0, 0, RV,    2'd0, 1};
        vt[15] = '{0, 0, 8'h00, 1, 0, RV,    2'd0, 1};
        // Flush with emit: 0x5 is visible for the emitting cycle
        vt[16] = '{0, 1, 8'h05, 0, 1, 8'h05, 2'd1, 1};
        vt[17] = '{1, 0, 8'h00, 1, 0, RV,    2'd0, 1};
    end

    initial begin
        logic [CW-1:0] cnt_exp[5];
        logic [DW-1:0] rd;
        nRST      = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        model_reset();
        #12;
        check("rst.in_ready",  int'(in_ready),  1);
        check("rst.out_valid", int'(out_valid), 0);
        check("rst.out_data",  int'(out_data),  int'(RV));
        check("rst.level",     int'(level),     0);
        check("rst.stall_cnt", int'(stall_cnt), 0);
        nRST = 1'b1;

        // Table
        for (int i = 0; i < 18; i++) begin
            step($sformatf("vec%0d", i), vt[i].fl, vt[i].iv, vt[i].d, vt[i].ordy);
            check($sformatf("vec%0d.ov",  i), int'(out_valid), int'(vt[i].e_ov));
            check($sformatf("vec%0d.od",  i), int'(out_data),  int'(vt[i].e_od));
            check($sformatf("vec%0d.lvl", i), int'(level),     int'(vt[i].e_lvl));
            check($sformatf("vec%0d.rdy", i), int'(in_ready),  int'(vt[i].e_rdy));
        end

        // Asynchronous reset while in SKID, checked before any clock edge
        step("arst.fill0", 0, 1, 8'hA1, 0);
        step("arst.fill1", 0, 1, 8'hA2, 0);
        check("arst.pre_level", int'(level), 2);
        #2;
        nRST = 1'b0;
        #1;
        check("arst.in_ready",  int'(in_ready),  1);
        check("arst.out_valid", int'(out_valid), 0);
        check("arst.out_data",  int'(out_data),  int'(RV));
        check("arst.level",     int'(level),     0);
        check("arst.stall_cnt", int'(stall_cnt), 0);
        model_reset();
        @(negedge CLK);
        nRST = 1'b1;

        // Stall counter: SKID with in_valid held for five cycles
`ifdef PIPE_STALL_CNT_EN
        cnt_exp = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
`else
        cnt_exp = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
`endif
        step("cnt.fill0", 0, 1, 8'hC1, 0);
        step("cnt.fill1", 0, 1, 8'hC2, 0);
        for (int i = 0; i < 5; i++) begin
            step($sformatf("cnt.hold%0d", i), 0, 1, 8'hEE, 0);
            check($sformatf("cnt.val%0d", i), int'(stall_cnt), int'(cnt_exp[i]));
        end
        step("cnt.flush", 1, 0, 8'h00, 0);
        check("cnt.after_flush", int'(stall_cnt), int'(cnt_exp[4]));
        check("cnt.flush_level", int'(level), 0);

        // Randomized run against the model
        for (int i = 0; i < 400; i++) begin
            rd = DW'($urandom);
            step("rnd", ($urandom_range(15) == 0), $urandom_range(1), rd,
                 ($urandom_range(3) != 0) ? 1'b1 : 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipe_skid_stage.md
Name: pipe_skid_stage

Overview:
Generic parametrised pipeline-stage register for the pipelined datapath. It replaces fixed per-stage latches that use an enable/nop pair with a valid/ready handshake stage. A 2-entry skid buffer gives full throughput with a registered in_ready, and a synchronous flush injects a bubble. One instance sits between each pair of pipeline stages; the stage payload (control and data fields) is packed into one DATA_W vector by the instantiating stage.

Parameters:
DATA_W, 64, payload width in bits (min 1)
RESET_VAL, 0, value loaded into all data registers on reset and on flush (DATA_W bits)
CNT_W, 16, width of the stall counter (used only with PIPE_STALL_CNT_EN)

Ports:
CLK  input  1  clock, rising edge
nRST  input  1  asynchronous active-low reset
flush  input  1  synchronous squash of all held entries (bubble insert)
in_valid  input  1  upstream has a payload
in_ready  output  1  stage can accept; registered, depends only on state
in_data  input  DATA_W  upstream payload
out_valid  output  1  out_data holds a live payload
out_ready  input  1  downstream accepts out_data this cycle
out_data  output  DATA_W  head payload, driven from the main register
level  output  2  entries held: 0, 1 or 2
stall_cnt  output  CNT_W  saturating stall counter (feature only)

Behaviour:
- Reset nRST, asynchronous, active-low; clock CLK. Reset takes effect immediately and overrides flush and handshakes.
- Registers: main (data), skid (data), state in {EMPTY, FULL, SKID}.
- Accept = in_valid & in_ready. Emit = out_valid & out_ready.
- Reset values: state=EMPTY, main=skid=RESET_VAL, in_ready=1, out_valid=0, out_data=RESET_VAL, level=0, stall_cnt=0.
- out_valid = (state!=EMPTY). in_ready = (state!=SKID). level: EMPTY=0, FULL=1, SKID=2.
- Latency: an accepted payload appears on out_data with out_valid=1 on the next cycle when the stage was EMPTY, or was FULL and emitted that cycle.
- EMPTY: on accept, main<=in_data and go to FULL; otherwise stay. out_ready is ignored.
- FULL:
  - accept and emit: main<=in_data, stay FULL (1 payload per cycle throughput).
  - accept only: skid<=in_data, go to SKID; main is unchanged.
  - emit only: go to EMPTY; main keeps its value.
  - neither: hold.
- SKID: in_ready=0, so in_valid is ignored. On emit, main<=skid and go to FULL. Otherwise hold both registers.
- Ordering is strictly FIFO. No payload is ever dropped or duplicated except by flush.
- Data registers load only on the transitions above (no enable gating beyond the handshake).
- flush=1: next state=EMPTY, main<=RESET_VAL, skid<=RESET_VAL. Any accept that cycle is discarded.
  - An emit in the same cycle still counts as completed for the consumer.
  - flush dominates every simultaneous event.
- Mid-operation reset: contents are lost, and outputs take reset values asynchronously.
- in_data/out_ready are don't-care when the corresponding valid/ready is low. Holding in_valid high with in_ready low is legal.

Optional Feature:
PIPE_STALL_CNT_EN
- Defined: stall_cnt increments each cycle with in_valid=1 & in_ready=0. It saturates at 2^CNT_W-1 (no wrap) and clears on reset only; flush does not clear it.
- Undefined: the counter logic is absent and stall_cnt is tied to 0.

Test Plan:
1. Reset: assert nRST=0 mid-cycle with state SKID -> outputs immediately in_ready=1, out_valid=0, out_data=RESET_VAL, level=0.
2. Streaming: out_ready=1, in_valid=1 with 0x11,0x22,0x33 on consecutive cycles -> out_data shows 0x11,0x22,0x33 on the following 3 cycles; in_ready stays 1; level stays 1.
3. Backpressure: out_ready=0, push 0xA then 0xB -> level=2 and in_ready=0. Hold 0xC on in_valid for 3 cycles, then out_ready=1 -> outputs 0xA, 0xB, 0xC in order with no loss.
4. Flush in SKID: with entries 0xA and 0xB held, flush=1 together with in_valid=1 and in_data=0xD -> next cycle out_valid=0, level=0, out_data=RESET_VAL, and 0xD is never emitted.
5. Flush with emit: in FULL with 0x5, out_ready=1 and flush=1 -> consumer receives 0x5 that cycle, then out_valid=0.
6. Counter (PIPE_STALL_CNT_EN, CNT_W=2): hold in_valid=1 in SKID for 5 cycles -> stall_cnt goes 1,2,3,3,3. A flush afterwards leaves it at 3.
